// File: rtl/pfram_pkg.sv
// Shared types for the playfield RAM arbiter: default widths, CPU FSM states
// and slot-owner encoding.
package pfram_pkg;

    localparam int PF_AW = 10;
    localparam int PF_DW = 8;

    typedef enum logic [1:0] {
        C_IDLE,
        C_RD_WAIT,
        C_WR_WAIT,
        C_ACK
    } cpu_state_t;

    typedef enum logic [1:0] {
        NONE,
        VID,
        CPU,
        WRBUF
    } slot_t;

endpackage

// File: rtl/pfram_arbiter_if.sv
// Video, CPU and RAM-side signals of the playfield RAM arbiter.
// slave = arbiter side, master = surrounding core (decoder, fetcher, RAM).
interface pfram_arbiter_if
    import pfram_pkg::*;
#(
    parameter int AW = PF_AW,
    parameter int DW = PF_DW
) ();

    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic [DW-1:0] vid_data;
    logic          vid_valid;

    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_starve;

    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    modport slave (
        input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
        output vid_data, vid_valid, cpu_ack, cpu_rdata, cpu_starve,
               ram_addr, ram_we, ram_wdata
    );

    modport master (
        output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
        input  vid_data, vid_valid, cpu_ack, cpu_rdata, cpu_starve,
               ram_addr, ram_we, ram_wdata
    );

endinterface

// File: rtl/pfram_wrbuf.sv
// One-entry posted CPU write buffer; only built when PFRAM_WRBUF_EN is defined.
`ifdef PFRAM_WRBUF_EN
module pfram_wrbuf
    import pfram_pkg::*;
#(
    parameter int AW = PF_AW,
    parameter int DW = PF_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          drain,
    input  logic [AW-1:0] addr_in,
    input  logic [DW-1:0] data_in,
    output logic          full,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] data
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
            addr <= '0;
            data <= '0;
        end else if (load) begin
            full <= 1'b1;
            addr <= addr_in;
            data <= data_in;
        end else if (drain) begin
            full <= 1'b0;
        end
    end

endmodule
`endif

// File: rtl/pfram_arbiter.sv
// Playfield RAM arbiter: video has absolute priority, then write-buffer drain,
// then CPU. Optional posted write buffer enabled by PFRAM_WRBUF_EN.
module pfram_arbiter
    import pfram_pkg::*;
#(
    parameter int AW       = PF_AW,
    parameter int DW       = PF_DW,
    parameter int MAX_WAIT = 16
) (
    input  logic clk_12mhz,
    input  logic reset_n,
    pfram_arbiter_if.slave bus
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);
`ifdef PFRAM_WRBUF_EN
    localparam bit WB_EN = 1'b1;
`else
    localparam bit WB_EN = 1'b0;
`endif

    cpu_state_t    state, state_nxt;
    slot_t         owner;
    logic          rd_cnt;
    logic          cpu_grant, cpu_wait;
    logic [CW-1:0] wait_cnt;
    logic          starve_q;

    logic          wb_full;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;

    logic [AW-1:0] acc_addr;
    logic          acc_we;
    logic [DW-1:0] acc_wdata;

    logic          vid_p1, vid_p2, vid_valid_q;
    logic [DW-1:0] vid_data_q;
    logic          cpu_ack_q;
    logic [DW-1:0] cpu_rdata_q;
    logic [AW-1:0] ram_addr_q;
    logic          ram_we_q;
    logic [DW-1:0] ram_wdata_q;

`ifdef PFRAM_WRBUF_EN
    pfram_wrbuf #(.AW(AW), .DW(DW)) u_wrbuf (
        .clk     (clk_12mhz),
        .rst_n   (reset_n),
        .load    (cpu_grant && bus.cpu_we),
        .drain   (owner == WRBUF),
        .addr_in (bus.cpu_addr),
        .data_in (bus.cpu_wdata),
        .full    (wb_full),
        .addr    (wb_addr),
        .data    (wb_data)
    );
`else
    assign wb_full = 1'b0;
    assign wb_addr = '0;
    assign wb_data = '0;
`endif

    always_comb begin
        // a full buffer claims the slot ahead of the CPU, which also blocks
        // new CPU reads/writes until the posted write has reached the RAM
        owner = NONE;
        if (bus.vid_req)
            owner = VID;
        else if (wb_full)
            owner = WRBUF;
        else if (state == C_IDLE && bus.cpu_req)
            owner = CPU;

        cpu_grant = (owner == CPU);
        cpu_wait  = (state == C_IDLE) && bus.cpu_req && !cpu_grant;

        acc_addr  = ram_addr_q;
        acc_we    = 1'b0;
        acc_wdata = ram_wdata_q;
        case (owner)
            VID:   acc_addr = bus.vid_addr;
            WRBUF: begin
                acc_addr  = wb_addr;
                acc_we    = 1'b1;
                acc_wdata = wb_data;
            end
            CPU: begin
                if (!(bus.cpu_we && WB_EN)) begin
                    acc_addr = bus.cpu_addr;
                    acc_we   = bus.cpu_we;
                    if (bus.cpu_we)
                        acc_wdata = bus.cpu_wdata;
                end
            end
            default: ;
        endcase

        state_nxt = state;
        case (state)
            C_IDLE: begin
                if (cpu_grant) begin
                    if (!bus.cpu_we)
                        state_nxt = C_RD_WAIT;
                    else if (WB_EN)
                        state_nxt = C_ACK;
                    else
                        state_nxt = C_WR_WAIT;
                end
            end
            C_RD_WAIT: if (rd_cnt) state_nxt = C_ACK;
            C_WR_WAIT: state_nxt = C_ACK;
            C_ACK:     state_nxt = C_IDLE;
            default:   state_nxt = C_IDLE;
        endcase
    end

    always_ff @(posedge clk_12mhz or negedge reset_n) begin
        if (!reset_n) begin
            state       <= C_IDLE;
            rd_cnt      <= 1'b0;
            cpu_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            wait_cnt    <= '0;
            starve_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            rd_cnt    <= (state == C_RD_WAIT) ? ~rd_cnt : 1'b0;
            cpu_ack_q <= (state_nxt == C_ACK);
            if (state == C_RD_WAIT && rd_cnt)
                cpu_rdata_q <= bus.ram_rdata;
            if (cpu_grant)
                wait_cnt <= '0;
            else if (cpu_wait && wait_cnt != WAIT_MAX)
                wait_cnt <= wait_cnt + 1'b1;
            if (cpu_wait && wait_cnt >= WAIT_MAX - 1'b1)
                starve_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_12mhz or negedge reset_n) begin
        if (!reset_n) begin
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= '0;
            vid_p1      <= 1'b0;
            vid_p2      <= 1'b0;
            vid_valid_q <= 1'b0;
            vid_data_q  <= '0;
        end else begin
            ram_addr_q  <= acc_addr;
            ram_we_q    <= acc_we;
            ram_wdata_q <= acc_wdata;
            vid_p1      <= (owner == VID);
            vid_p2      <= vid_p1;
            vid_valid_q <= vid_p2;
            if (vid_p2)
                vid_data_q <= bus.ram_rdata;
        end
    end

    assign bus.vid_data   = vid_data_q;
    assign bus.vid_valid  = vid_valid_q;
    assign bus.cpu_ack    = cpu_ack_q;
    assign bus.cpu_rdata  = cpu_rdata_q;
    assign bus.cpu_starve = starve_q;
    assign bus.ram_addr   = ram_addr_q;
    assign bus.ram_we     = ram_we_q;
    assign bus.ram_wdata  = ram_wdata_q;

endmodule

// File: tb/tb_pfram_arbiter.sv
// Directed testbench for pfram_arbiter with a synchronous-read RAM model;
// expectations adapt to PFRAM_WRBUF_EN.
module tb_pfram_arbiter;

    localparam int AW       = 10;
    localparam int DW       = 8;
    localparam int MAX_WAIT = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    logic [DW-1:0] mem [0:1023];
    logic          loaded = 1'b0;

    pfram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    pfram_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
        .clk_12mhz (clk),
        .reset_n   (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // RAM model: first edge preloads known words, afterwards 1-cycle read
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 1024; i++) mem[i] <= '0;
            mem[10'h123] <= 8'h5A;
            mem[10'h040] <= 8'h77;
            mem[10'h100] <= 8'h11;
            mem[10'h200] <= 8'h22;
            loaded <= 1'b1;
        end else begin
            if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
            bus.ram_rdata <= mem[bus.ram_addr];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.vid_req   = 1'b0;
        bus.vid_addr  = '0;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
    endtask

    task automatic test_reset;
        logic [43:0] outs;
        idle_inputs();
        rst_n = 1'b0;
        step();
        step();
        outs = {bus.vid_valid, bus.vid_data, bus.cpu_ack, bus.cpu_rdata, bus.cpu_starve,
                bus.ram_we, bus.ram_addr, bus.ram_wdata};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", outs);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_video_read;
        logic ack_seen = 1'b0;
        bus.vid_req  = 1'b1;
        bus.vid_addr = 10'h123;
        step();
        bus.vid_req = 1'b0;
        ack_seen |= bus.cpu_ack;
        checks++;
        if (bus.ram_addr !== 10'h123 || bus.ram_we !== 1'b0) begin
            errors++;
            $display("FAIL vid_ram_addr: got %h we=%b expected 123 we=0", bus.ram_addr, bus.ram_we);
        end
        step();
        ack_seen |= bus.cpu_ack;
        checks++;
        if (bus.vid_valid !== 1'b0) begin
            errors++;
            $display("FAIL vid_valid_early: got %b expected 0", bus.vid_valid);
        end
        step();
        ack_seen |= bus.cpu_ack;
        checks++;
        if (bus.vid_valid !== 1'b1 || bus.vid_data !== 8'h5A) begin
            errors++;
            $display("FAIL vid_data: got valid=%b data=%h expected valid=1 data=5a", bus.vid_valid, bus.vid_data);
        end
        step();
        ack_seen |= bus.cpu_ack;
        checks++;
        if (bus.vid_valid !== 1'b0) begin
            errors++;
            $display("FAIL vid_valid_pulse: got %b expected 0", bus.vid_valid);
        end
        checks++;
        if (ack_seen !== 1'b0) begin
            errors++;
            $display("FAIL vid_no_ack: got cpu_ack=%b expected 0", ack_seen);
        end
    endtask

    task automatic test_cpu_read;
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 10'h040;
        step();
        checks++;
        if (bus.ram_addr !== 10'h040 || bus.ram_we !== 1'b0) begin
            errors++;
            $display("FAIL cpu_rd_addr: got %h we=%b expected 040 we=0", bus.ram_addr, bus.ram_we);
        end
        step();
        checks++;
        if (bus.cpu_ack !== 1'b0) begin
            errors++;
            $display("FAIL cpu_rd_ack_early: got %b expected 0", bus.cpu_ack);
        end
        step();
        checks++;
        if (bus.cpu_ack !== 1'b1 || bus.cpu_rdata !== 8'h77) begin
            errors++;
            $display("FAIL cpu_rd_data: got ack=%b data=%h expected ack=1 data=77", bus.cpu_ack, bus.cpu_rdata);
        end
        bus.cpu_req = 1'b0;
        step();
        checks++;
        if (bus.cpu_ack !== 1'b0) begin
            errors++;
            $display("FAIL cpu_ack_pulse: got %b expected 0", bus.cpu_ack);
        end
    endtask

    task automatic test_collision;
        bus.vid_req  = 1'b1;
        bus.vid_addr = 10'h100;
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 10'h200;
        step();
        bus.vid_req = 1'b0;
        checks++;
        if (bus.ram_addr !== 10'h100) begin
            errors++;
            $display("FAIL coll_vid_first: got %h expected 100", bus.ram_addr);
        end
        step();
        checks++;
        if (bus.ram_addr !== 10'h200) begin
            errors++;
            $display("FAIL coll_cpu_next: got %h expected 200", bus.ram_addr);
        end
        step();
        checks++;
        if (bus.vid_valid !== 1'b1 || bus.vid_data !== 8'h11) begin
            errors++;
            $display("FAIL coll_vid_data: got valid=%b data=%h expected valid=1 data=11", bus.vid_valid, bus.vid_data);
        end
        step();
        checks++;
        if (bus.cpu_ack !== 1'b1 || bus.cpu_rdata !== 8'h22) begin
            errors++;
            $display("FAIL coll_cpu_data: got ack=%b data=%h expected ack=1 data=22", bus.cpu_ack, bus.cpu_rdata);
        end
        bus.cpu_req = 1'b0;
        step();
    endtask

    task automatic test_write_read;
        logic got = 1'b0;
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 10'h3FF;
        bus.cpu_wdata = 8'hA5;
        step();
`ifdef PFRAM_WRBUF_EN
        checks++;
        if (bus.cpu_ack !== 1'b1 || bus.ram_we !== 1'b0) begin
            errors++;
            $display("FAIL wr_posted_ack: got ack=%b we=%b expected ack=1 we=0", bus.cpu_ack, bus.ram_we);
        end
        bus.cpu_req = 1'b0;
        bus.cpu_we  = 1'b0;
        step();
        checks++;
        if (bus.ram_we !== 1'b1 || bus.ram_addr !== 10'h3FF || bus.ram_wdata !== 8'hA5) begin
            errors++;
            $display("FAIL wr_drain: got we=%b addr=%h data=%h expected we=1 addr=3ff data=a5",
                     bus.ram_we, bus.ram_addr, bus.ram_wdata);
        end
`else
        checks++;
        if (bus.ram_we !== 1'b1 || bus.ram_addr !== 10'h3FF || bus.ram_wdata !== 8'hA5 || bus.cpu_ack !== 1'b0) begin
            errors++;
            $display("FAIL wr_direct: got we=%b addr=%h data=%h ack=%b expected we=1 addr=3ff data=a5 ack=0",
                     bus.ram_we, bus.ram_addr, bus.ram_wdata, bus.cpu_ack);
        end
        step();
        checks++;
        if (bus.cpu_ack !== 1'b1 || bus.ram_we !== 1'b0) begin
            errors++;
            $display("FAIL wr_ack: got ack=%b we=%b expected ack=1 we=0", bus.cpu_ack, bus.ram_we);
        end
        bus.cpu_req = 1'b0;
        bus.cpu_we  = 1'b0;
`endif
        step();
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 10'h3FF;
        for (int i = 0; i < 12 && !got; i++) begin
            step();
            if (bus.cpu_ack === 1'b1) got = 1'b1;
        end
        checks++;
        if (!got || bus.cpu_rdata !== 8'hA5) begin
            errors++;
            $display("FAIL raw_read: got ack=%b data=%h expected ack=1 data=a5", got, bus.cpu_rdata);
        end
        bus.cpu_req = 1'b0;
        step();
    endtask

    task automatic test_starve;
        logic got = 1'b0;
        bus.vid_req  = 1'b1;
        bus.vid_addr = 10'h001;
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 10'h040;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 15) begin
                checks++;
                if (bus.cpu_starve !== 1'b0) begin
                    errors++;
                    $display("FAIL starve_early: got %b expected 0 after 15 waits", bus.cpu_starve);
                end
            end
            if (i == 16) begin
                checks++;
                if (bus.cpu_starve !== 1'b1) begin
                    errors++;
                    $display("FAIL starve_set: got %b expected 1 after 16 waits", bus.cpu_starve);
                end
            end
        end
        bus.vid_req = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            step();
            if (bus.cpu_ack === 1'b1) got = 1'b1;
        end
        checks++;
        if (!got || bus.cpu_rdata !== 8'h77) begin
            errors++;
            $display("FAIL starve_recover: got ack=%b data=%h expected ack=1 data=77", got, bus.cpu_rdata);
        end
        bus.cpu_req = 1'b0;
        step();
        checks++;
        if (bus.cpu_starve !== 1'b1) begin
            errors++;
            $display("FAIL starve_sticky: got %b expected 1", bus.cpu_starve);
        end
    endtask

    task automatic test_reset_mid_op;
        logic [43:0] outs;
        logic        bad = 1'b0;
        logic        got = 1'b0;
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 10'h040;
        step();
        rst_n = 1'b0;
        bus.cpu_req = 1'b0;
        #1;
        outs = {bus.vid_valid, bus.vid_data, bus.cpu_ack, bus.cpu_rdata, bus.cpu_starve,
                bus.ram_we, bus.ram_addr, bus.ram_wdata};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got %h expected 0", outs);
        end
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            bad |= bus.cpu_ack;
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_no_ack: got cpu_ack=%b expected 0", bad);
        end
`ifdef PFRAM_WRBUF_EN
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 10'h155;
        bus.cpu_wdata = 8'h3C;
        step();
        rst_n = 1'b0;
        bus.cpu_req = 1'b0;
        bus.cpu_we  = 1'b0;
        step();
        rst_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            bad |= bus.ram_we;
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL rst_wrbuf_drop: got ram_we=%b expected 0", bad);
        end
`endif
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 10'h040;
        for (int i = 0; i < 12 && !got; i++) begin
            step();
            if (bus.cpu_ack === 1'b1) got = 1'b1;
        end
        checks++;
        if (!got || bus.cpu_rdata !== 8'h77) begin
            errors++;
            $display("FAIL rst_then_read: got ack=%b data=%h expected ack=1 data=77", got, bus.cpu_rdata);
        end
        bus.cpu_req = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_video_read();
        test_cpu_read();
        test_collision();
        test_write_read();
        test_starve();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pfram_arbiter.md
# pfram_arbiter

Shares the single-port, synchronous-read playfield RAM between the video tile fetcher and the 6502 CPU bus. Video holds absolute priority with a fixed-latency read path. The CPU uses a level request / pulse acknowledge handshake. It sits between the CPU address decoder, the video fetch logic and the playfield RAM inside the centipede core, clocked from the 12 MHz system clock.

## Interface
- AW, 10, RAM address width (1 KB playfield)
- DW, 8, RAM data width
- MAX_WAIT, 16, CPU wait cycles before cpu_starve sets
- clk_12mhz  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- vid_req  in  1  video read request, single-cycle, never held
- vid_addr  in  AW  video read address, valid with vid_req
- vid_data  out  DW  video read data, valid with vid_valid
- vid_valid  out  1  one-cycle pulse, video data returned
- cpu_req  in  1  CPU request, level; addr/we/wdata stable until ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_ack  out  1  one-cycle pulse, transaction complete
- cpu_rdata  out  DW  CPU read data, valid with cpu_ack on reads
- ram_addr  out  AW  registered RAM address
- ram_we  out  1  registered RAM write strobe
- ram_wdata  out  DW  registered RAM write data
- ram_rdata  in  DW  RAM read data, 1 cycle after address sampled
- cpu_starve  out  1  sticky flag, CPU waited ≥ MAX_WAIT cycles

## Operation
- Each cycle the slot is granted in priority order: vid_req, then write-buffer drain, then new CPU request.
- Every RAM access occupies one slot. ram_addr, ram_we and ram_wdata are registered from the winning requester.
- Idle slot: ram_we = 0 and ram_addr holds its last value.
- CPU FSM states and transitions:
  - C_IDLE: CPU request eligible.
  - C_RD_WAIT: 2 cycles, read in flight.
  - C_WR_WAIT: 1 cycle, unbuffered write in flight.
  - C_ACK: pulse cpu_ack, then return to C_IDLE.
- A new CPU transaction is considered from the cycle after C_ACK. Back-to-back requests with cpu_req held high are legal.
- A CPU read is not eligible while the write buffer is full. This guarantees read-after-write ordering.
- A CPU write is not eligible while the write buffer is full.
- Wait counter: counts cycles in which cpu_req is high in C_IDLE and not granted. It saturates at MAX_WAIT. When it reaches MAX_WAIT, cpu_starve sets and stays set until reset. The counter clears on grant.
- Reset values: all outputs 0. The FSM returns to C_IDLE and the write buffer empties.
- Reset asserted mid-operation drops any in-flight read and any buffered write. No vid_valid or cpu_ack is produced for them.

## Timing
- Video read:
  - vid_req sampled at the end of cycle 0.
  - ram_addr driven in cycle 1.
  - ram_rdata arrives in cycle 2.
  - vid_data and vid_valid in cycle 3.
  - Fixed latency of 3, never stalled.
- CPU read, granted in cycle g: RAM access in g+1, cpu_ack and cpu_rdata in g+3.
- CPU write, unbuffered: ram_we in g+1, cpu_ack in g+2.
- vid_req and cpu_req in the same cycle: video wins. The CPU retries next cycle and the wait counter increments.
- Video requests on every cycle starve the CPU indefinitely. cpu_starve reports this. It is not an error.

## Configuration
- PFRAM_WRBUF_EN defined:
  - A one-entry posted write buffer is present.
  - A CPU write is accepted when the buffer is empty. cpu_ack follows in the next cycle.
  - The buffer drains in the first slot not taken by video. ram_we fires then.
- PFRAM_WRBUF_EN undefined:
  - No buffer.
  - Writes follow the C_WR_WAIT path.
  - The buffer-full gating is constant-false.

## Structure
- Shared package pfram_pkg holds:
  - AW and DW defaults.
  - The CPU FSM state encoding: C_IDLE, C_RD_WAIT, C_WR_WAIT, C_ACK.
  - The slot-owner encoding: NONE, VID, CPU, WRBUF.
- One sub-module, pfram_wrbuf: holds the address/data pair and full flag, with load and drain strobes. It is instantiated only under PFRAM_WRBUF_EN.
- Top holds the grant logic, the 3-stage video valid pipe, the CPU FSM and the wait counter.

## Test plan
- Reset, then vid_req with vid_addr=0x123 and RAM model word 0x5A → vid_valid exactly 3 cycles later with vid_data=0x5A. No cpu_ack.
- CPU read of 0x040 (0x77) with no video traffic → ram_addr=0x040 one cycle after grant. cpu_ack with cpu_rdata=0x77 at g+3.
- vid_req and CPU read issued in the same cycle → video access first. CPU access in the next slot. Video latency unchanged at 3.
- CPU write 0x3FF←0xA5, then read 0x3FF (WRBUF on and off) → read returns 0xA5. With buffer: write ack 1 cycle after grant.
- vid_req held every cycle for 20 cycles with cpu_req high → cpu_starve sets on the 16th waiting cycle and stays set after video stops.
- Assert reset_n low during C_RD_WAIT → no cpu_ack. All outputs 0. Buffer empty after release.
